imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader_pkg.sv | 14 +
 rtl/imem_word_packer.sv | 23 ++
 rtl/imem_loader.sv | 77 +++++++
 tb/tb_imem_loader.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: loader FSM encoding (S_CSUM only with IMEM_LOADER_CHECKSUM_EN) and stream header length.
package imem_loader_pkg;
  localparam int HDR_LEN = 2;
  typedef enum logic [2:0] {
    S_LEN0 = 3'd0,
    S_LEN1 = 3'd1,
    S_DATA = 3'd2,
`ifdef IMEM_LOADER_CHECKSUM_EN
    S_CSUM = 3'd3,
`endif
    S_DONE = 3'd4,
    S_ERR  = 3'd5
  } state_t;
endpackage

// File: rtl/imem_word_packer.sv
// imem_word_packer: shifts in 4 little-endian bytes and pulses word_done the cycle after the 4th.
module imem_word_packer (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [7:0]  din,
  output logic [31:0] word,
  output logic        word_done
);
  logic [1:0] cnt;
  always_ff @(posedge clk)
    if (reset) begin
      cnt       <= '0;
      word      <= '0;
      word_done <= 1'b0;
    end else begin
      word_done <= en && cnt == 2'd3;
      if (en) begin
        cnt  <= cnt + 2'd1;
        word <= {din, word[31:8]};
      end
    end
endmodule

// File: rtl/imem_loader.sv
// imem_loader: byte-stream instruction-memory loader; define IMEM_LOADER_CHECKSUM_EN for a trailing XOR check byte.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_reset,
  output logic              done,
  output logic              error
);
  localparam int unsigned DEPTH = 1 << ADDR_W;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_t S_FIN = S_CSUM;
`else
  localparam state_t S_FIN = S_DONE;
`endif
  state_t state, state_nx;
  logic [8*HDR_LEN-1:0] n, n_hdr;
  logic [ADDR_W-1:0] widx;
  logic accept, last;
  assign accept    = in_valid && in_ready;
  assign n_hdr     = {in_data, n[7:0]};
  assign last      = widx == ADDR_W'(n - 1'b1);
  assign imem_addr = widx;
  imem_word_packer u_pack (
    .clk       (clk),
    .reset     (reset),
    .en        (accept && state == S_DATA),
    .din       (in_data),
    .word      (imem_wdata),
    .word_done (imem_we)
  );
  always_ff @(posedge clk)
    if (reset) begin
      state <= S_LEN0;
      n     <= '0;
      widx  <= '0;
    end else begin
      state <= state_nx;
      if (accept && state == S_LEN0) n[7:0] <= in_data;
      if (accept && state == S_LEN1) n[15:8] <= in_data;
      if (imem_we) widx <= widx + 1'b1;
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] csum;
  always_ff @(posedge clk)
    if (reset) csum <= '0;
    else if (accept && state == S_DATA) csum <= csum ^ in_data;
`endif
  always_comb begin
    state_nx = state;
    case (state)
      S_LEN0: if (accept) state_nx = S_LEN1;
      S_LEN1: if (accept) state_nx = n_hdr == '0 ? S_FIN : 32'(n_hdr) > DEPTH ? S_ERR : S_DATA;
      S_DATA: if (imem_we && last) state_nx = S_FIN;
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CSUM: if (accept) state_nx = in_data == csum ? S_DONE : S_ERR;
`endif
      default: ;
    endcase
  end
  // Ready drops during the final strobe so a following byte is never swallowed as payload.
  always_comb begin
    in_ready  = state != S_DONE && state != S_ERR && !(state == S_DATA && imem_we && last);
    done      = state == S_DONE;
    error     = state == S_ERR;
    cpu_reset = state != S_DONE;
  end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: scoreboard bench for imem_loader; IMEM_LOADER_CHECKSUM_EN selects checksum-build expectations.
module tb_imem_loader;
  logic clk = 1'b0, reset = 1'b1, in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic in_ready, imem_we, cpu_reset, done, error;
  logic [5:0] imem_addr;
  logic [31:0] imem_wdata;
  int compared = 0, mismatched = 0;
  logic [37:0] exp_q[$];
  logic [37:0] e_w;
  logic [7:0] csum;
  logic [7:0] stream [18] = '{8'h04, 8'h00, 8'h03, 8'h03, 8'h03, 8'h00, 8'h03, 8'h03, 8'h13, 8'h00,
                              8'h33, 8'h03, 8'ha3, 8'h00, 8'h13, 8'h03, 8'ha3, 8'ha2};
  logic [31:0] words [4] = '{32'h00030303, 32'h00130303, 32'h00a30333, 32'ha2a30313};

  always #5 clk = ~clk;

  imem_loader #(.ADDR_W(6)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_reset  (cpu_reset),
    .done       (done),
    .error      (error)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk)
    if (!reset && imem_we) begin
      chk("write_pending", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        e_w = exp_q.pop_front();
        chk("write_addr", 32'(imem_addr), 32'(e_w[37:32]));
        chk("write_data", imem_wdata, e_w[31:0]);
        chk("write_cpu_reset", 32'(cpu_reset), 32'd1);
      end
    end

  task automatic send(input logic [7:0] b, input int gap);
    int t = 0;
    while (!in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (t == 20) chk("ready_timeout", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_data  = b;
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 8'($urandom);
    repeat (gap) @(negedge clk);
  endtask

  task automatic load(input int gap_max);
    foreach (words[i]) exp_q.push_back({6'(i), words[i]});
    foreach (stream[i]) send(stream[i], int'($urandom_range(gap_max, 0)));
`ifdef IMEM_LOADER_CHECKSUM_EN
    send(csum, 0);
`endif
  endtask

  task automatic expect_end(input string tag, input logic d, input logic e);
    int t = 0;
    while (!(done || error) && t < 40) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_done"}, 32'(done), 32'(d));
    chk({tag, "_error"}, 32'(error), 32'(e));
    chk({tag, "_cpu_reset"}, 32'(cpu_reset), 32'(!d));
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    chk({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    csum = 8'h00;
    for (int i = 2; i < 18; i++) csum ^= stream[i];
    @(negedge clk);
    do_reset();
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_imem_we", 32'(imem_we), 32'd0);
    chk("rst_imem_addr", 32'(imem_addr), 32'd0);
    chk("rst_imem_wdata", imem_wdata, 32'd0);
    chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    load(0);
    expect_end("normal", 1'b1, 1'b0);
    in_valid = 1'b1;
    repeat (4) @(negedge clk);
    in_valid = 1'b0;
    chk("sticky_done", 32'(done), 32'd1);
    chk("sticky_cpu_reset", 32'(cpu_reset), 32'd0);
    do_reset();
    chk("rerst_addr", 32'(imem_addr), 32'd0);
    chk("rerst_done", 32'(done), 32'd0);
    chk("rerst_cpu_reset", 32'(cpu_reset), 32'd1);
    send(8'h00, 0);
    send(8'h00, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send(8'h00, 0);
`endif
    expect_end("n0", 1'b1, 1'b0);
    do_reset();
    send(8'h40, 0);
    send(8'h00, 0);
    chk("n64_error", 32'(error), 32'd0);
    chk("n64_in_ready", 32'(in_ready), 32'd1);
    do_reset();
    send(8'h41, 0);
    send(8'h00, 0);
    expect_end("oversize", 1'b0, 1'b1);
    do_reset();
    load(3);
    expect_end("gaps", 1'b1, 1'b0);
    do_reset();
    exp_q.push_back({6'd0, words[0]});
    for (int i = 0; i < 8; i++) send(stream[i], 0);
    repeat (2) @(negedge clk);
    chk("midload_word0", 32'(exp_q.size()), 32'd0);
    do_reset();
    load(1);
    expect_end("after_reset", 1'b1, 1'b0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    do_reset();
    foreach (words[i]) exp_q.push_back({6'(i), words[i]});
    foreach (stream[i]) send(stream[i], 0);
    send(csum ^ 8'h01, 0);
    expect_end("bad_csum", 1'b0, 1'b1);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
